// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Address width for a file of n entries; never narrower than one bit.
    function automatic int rf_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every entry once, then holds READY.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    rf_state_e         state;
    rf_state_e         state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        clr_we       = 1'b0;
        init_done    = 1'b0;
        unique case (state)
            RF_CLEAR: begin
                clr_we       = 1'b1;
                clr_idx_next = clr_idx + 1'b1;
                if (clr_idx == LAST) begin
                    state_next = RF_READY;
                end
            end
            RF_READY: begin
                init_done = 1'b1;
            end
            default: begin
                state_next = RF_CLEAR;
            end
        endcase
    end

    assign clr_addr = clr_idx;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write bypass and a per-register busy
// scoreboard; storage is zeroed by regfile_init_seq after every reset.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b1,
    localparam int ADDR_W    = rf_addr_w(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         init_done,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_rd
);

    logic                  ready;
    logic                  clr_we;
    logic [ADDR_W-1:0]     clr_addr;
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   wr_hit;
    logic [DATA_WIDTH-1:0] wr_val [NUM_REGS];
    logic [NUM_WR-1:0]     wr_ok;
    logic                  issue_ok;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    regfile_init_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_init (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (ready)
    );

    assign init_done = ready;
    assign issue_ok  = issue_en && ready && addr_ok(issue_rd);

    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok[j] = ready && wr_en[j]
                && addr_ok(wr_addr[j*ADDR_W +: ADDR_W]);
        end
    end

    // Ascending port scan: the highest-numbered port to a register wins.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (clr_we && clr_addr == ADDR_W'(r)) begin
                mem[r] <= '0;
            end else if (wr_hit[r]) begin
                mem[r] <= wr_val[r];
            end
        end
    end

    // A new producer issuing on the same edge as the old one retiring
    // must leave the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (issue_ok && issue_rd == ADDR_W'(r)) begin
                    busy[r] <= 1'b1;
                end else if (wr_hit[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            if (ready && addr_ok(ra)) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (ra == ADDR_W'(r)) begin
                        rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                            (BYPASS && wr_hit[r]) ? wr_val[r] : mem[r];
                        rd_busy[i] = busy[r] & ~(BYPASS & wr_hit[r]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and randomized checks of regfile_mp_sb against an
// array-based reference model of the architectural register state.
module tb_regfile_mp_sb;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               init_done;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*DW-1:0]  rd_data;
    logic [NRD-1:0]     rd_busy;
    logic [NWR-1:0]     wr_en;
    logic [NWR*AW-1:0]  wr_addr;
    logic [NWR*DW-1:0]  wr_data;
    logic               issue_en;
    logic [AW-1:0]      issue_rd;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_reg [NR];
    bit            m_busy [NR];
    bit            m_ready;
    int            m_clr;

    regfile_mp_sb #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_RD     (NRD),
        .NUM_WR     (NWR),
        .BYPASS     (1'b1),
        .ZERO_REG   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int wa(input int j);
        return int'(wr_addr[j*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] exp_data(input int a);
        logic [DW-1:0] v;
        if (!m_ready || a == 0) return '0;
        v = m_reg[a];
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wa(j) == a) v = wr_data[j*DW +: DW];
        return v;
    endfunction

    function automatic logic exp_busy(input int a);
        if (!m_ready || a == 0) return 1'b0;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wa(j) == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
        end else if (!m_ready) begin
            m_clr++;
            if (m_clr == NR) begin
                m_ready = 1'b1;
                foreach (m_reg[r]) m_reg[r] = '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wa(j) != 0) begin
                    m_reg[wa(j)]  = wr_data[j*DW +: DW];
                    m_busy[wa(j)] = 1'b0;
                end
            end
            if (issue_en && issue_rd != '0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    task automatic cyc();
        int a;
        #4;
        check("init_done", 32'(init_done), 32'(m_ready));
        for (int i = 0; i < NRD; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            check($sformatf("rd_data%0d_x%0d", i, a),
                  rd_data[i*DW +: DW], exp_data(a));
            check($sformatf("rd_busy%0d_x%0d", i, a),
                  32'(rd_busy[i]), 32'(exp_busy(a)));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        issue_en = 1'b0;
        issue_rd = '0;
    endtask

    task automatic wr(input int j, input int a, input logic [DW-1:0] d);
        wr_en[j]            = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*DW +: DW] = d;
    endtask

    task automatic rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic randomize_inputs(input int span);
        for (int j = 0; j < NWR; j++) begin
            wr_en[j]            = 1'($urandom_range(0, 1));
            wr_addr[j*AW +: AW] = AW'($urandom_range(0, span));
            wr_data[j*DW +: DW] = $urandom;
        end
        for (int i = 0; i < NRD; i++) rd(i, $urandom_range(0, span));
        issue_en = 1'($urandom_range(0, 1));
        issue_rd = AW'($urandom_range(0, span));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        m_ready = 1'b0;
        m_clr   = 0;
        foreach (m_busy[r]) m_busy[r] = 1'b0;
        #1;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(rd_busy), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        idle();
        #1;
        do_reset();

        // 1: clear sequence, traffic during CLEAR must be ignored
        for (int k = 0; k < NR; k++) begin
            randomize_inputs(NR - 1);
            cyc();
        end
        idle();
        rd(0, 5);
        rd(1, 17);
        #1;
        check("t1_init_done", 32'(init_done), 32'd1);
        check("t1_rd_x5", rd_data[0 +: DW], 32'd0);
        check("t1_busy", 32'(rd_busy), 32'd0);
        cyc();

        // 2: write with same-cycle bypass
        wr(0, 5, 32'hDEAD_BEEF);
        #1;
        check("t2_bypass", rd_data[0 +: DW], 32'hDEAD_BEEF);
        cyc();
        idle();
        #1;
        check("t2_next", rd_data[0 +: DW], 32'hDEAD_BEEF);
        cyc();

        // 3: x0 hardwired
        wr(0, 0, 32'h1234);
        rd(0, 0);
        issue_en = 1'b1;
        issue_rd = '0;
        #1;
        check("t3_x0_bypass", rd_data[0 +: DW], 32'd0);
        cyc();
        idle();
        #1;
        check("t3_x0", rd_data[0 +: DW], 32'd0);
        check("t3_x0_busy", 32'(rd_busy[0]), 32'd0);
        cyc();

        // 4: two ports to one register
        wr(0, 7, 32'hA);
        wr(1, 7, 32'hB);
        rd(1, 7);
        #1;
        check("t4_bypass", rd_data[DW +: DW], 32'hB);
        cyc();
        idle();
        #1;
        check("t4_x7", rd_data[DW +: DW], 32'hB);
        cyc();

        // 5: scoreboard set/clear ordering
        rd(0, 3);
        issue_en = 1'b1;
        issue_rd = AW'(3);
        cyc();
        idle();
        #1;
        check("t5_busy", 32'(rd_busy[0]), 32'd1);
        wr(0, 3, 32'h33);
        issue_en = 1'b1;
        issue_rd = AW'(3);
        cyc();
        idle();
        #1;
        check("t5_set_wins", 32'(rd_busy[0]), 32'd1);
        wr(1, 3, 32'h44);
        #1;
        check("t5_bypass_busy", 32'(rd_busy[0]), 32'd0);
        cyc();
        idle();
        #1;
        check("t5_cleared", 32'(rd_busy[0]), 32'd0);
        check("t5_x3", rd_data[0 +: DW], 32'h44);
        cyc();

        // 6: reset mid-write, then again mid-clear
        issue_en = 1'b1;
        issue_rd = AW'(9);
        cyc();
        idle();
        rd(0, 9);
        wr(0, 9, 32'h55);
        issue_en = 1'b1;
        issue_rd = AW'(4);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            randomize_inputs(NR - 1);
            cyc();
        end
        do_reset();
        for (int k = 0; k < NR; k++) begin
            randomize_inputs(NR - 1);
            cyc();
        end
        idle();
        rd(0, 5);
        rd(1, 9);
        #1;
        check("t6_init_done", 32'(init_done), 32'd1);
        check("t6_x5", rd_data[0 +: DW], 32'd0);
        check("t6_x9", rd_data[DW +: DW], 32'd0);
        check("t6_busy", 32'(rd_busy), 32'd0);
        cyc();

        // randomized traffic concentrated on a few registers
        for (int k = 0; k < 400; k++) begin
            randomize_inputs((k % 4 == 0) ? NR - 1 : 7);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
